requant_arbiter: RTL and testbench
==================================

# requant_arbiter

Round-robin arbiter that shares one vectorized `requantize` engine between `NREQ` convolution engines, each of which produces OUT_CH-wide ACC_W accumulator vectors. It registers the granted vector together with that requester's `layer_sel` and presents both to the requantizer and `requant_params_rom`. It tracks in-flight beats with a tag pipeline matched to `REQ_LATENCY`, and routes each int8 result vector back to its requester. A drain FSM quiesces the engine so layer parameters can be swapped safely.

## Interface
- `NREQ`, 2: number of requesters (2..4)
- `CH`, 16: vector length (OUT_CH)
- `ACC_W`, 32: accumulator width per element
- `REQ_LATENCY`, 1: requantize in_valid→out_valid latency in cycles (≥1)
- `LSEL_W`, 2: layer_sel width
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `req_valid`  in  [NREQ]  requester i holds a vector
- `req_ready`  out  [NREQ]  one-hot grant; the beat is accepted when valid&ready
- `req_data`  in  [NREQ][CH] signed ACC_W  accumulator vectors
- `req_layer`  in  [NREQ] LSEL_W  layer_sel for the requester's beat
- `rq_in_data`  out  [CH] signed ACC_W  to requantize in_data
- `rq_in_valid`  out  1  to requantize in_valid
- `rq_layer_sel`  out  LSEL_W  to requant_params_rom layer_sel
- `rq_out_valid`  in  1  requantize out_valid
- `resp_valid`  out  [NREQ]  one-hot pulse; requantize out_data belongs to requester i
- `drain`  in  1  level; stop granting and empty the pipeline
- `idle`  out  1  no beat is registered or in flight, and the FSM is in S_DRAINED or S_RUN
- `err`  out  1  sticky tag/valid mismatch (see Configuration)

## Operation
- FSM states:
  - S_RUN: grants are issued.
  - S_DRAIN: no grants; wait until `rq_in_valid`=0 and the tag pipe is empty.
  - S_DRAINED: `idle`=1, no grants.
- FSM transitions:
  - S_RUN→S_DRAIN when `drain`=1.
  - S_DRAIN→S_DRAINED when the pipeline is empty.
  - S_DRAINED→S_RUN when `drain`=0.
  - S_DRAIN→S_RUN when `drain` deasserts before the pipeline empties.
- Arbitration:
  - Round-robin pointer `ptr`. The grant goes to the first i with `req_valid[i]`=1, searching from `ptr` upward modulo NREQ.
  - At most one grant per cycle.
  - After an accepted beat, `ptr` ← granted index + 1 (mod NREQ). `ptr` is unchanged when nothing is accepted.
- `req_ready` is combinational from `req_valid`, `ptr` and state. It is 0 in S_DRAIN and S_DRAINED.
- Issue register: on acceptance, capture `req_data[g]`, `req_layer[g]` and the tag g. Drive `rq_in_valid`=1 on the next cycle; otherwise `rq_in_valid`=0.
- `rq_layer_sel` holds its last value while `rq_in_valid`=0.
- Tag pipe: a shift register of depth REQ_LATENCY carrying {valid, tag}. It is loaded from the issue register each cycle.
- `resp_valid[tag]` = `rq_out_valid` & head.valid. This is combinational; requesters must consume the output in that cycle because there is no backpressure.
- No arithmetic is performed on data; vectors pass bit-exact.

## Timing
- Reset values:
  - `rq_in_valid`=0, `rq_in_data`=0, `rq_layer_sel`=0
  - `resp_valid`=0, `err`=0, `ptr`=0
  - FSM in S_RUN, tag pipe cleared
  - `idle`=1, because it is combinational from state and pipe occupancy
- Latency:
  - Beat accepted at cycle t → `rq_in_valid` at t+1.
  - `resp_valid` at t+1+REQ_LATENCY.
- Throughput: one beat per cycle sustained.
- Reset asserted mid-operation: in-flight beats are discarded and no `resp_valid` is produced for them.
- Simultaneous `drain` rising and a valid request: no grant that cycle. `drain` is sampled combinationally into `req_ready` gating.
- Requester i drops `req_valid` without a grant: legal. Its data must be stable while `req_valid`=1 and `req_ready`=0.

## Configuration
- `REQ_ARB_CHECK_EN` defined:
  - `err` is set when `rq_out_valid`=1 while head.valid=0.
  - `err` is also set when head.valid=1 and `rq_out_valid`=0.
  - `err` is cleared only by `rst`.
- `REQ_ARB_CHECK_EN` not defined: `err` is tied 0 and the check logic is absent.

## Structure
- Shared package `cnn_pkg`:
  - constant for max NREQ
  - `arb_state_t` enum {S_RUN, S_DRAIN, S_DRAINED}
  - tag struct {valid, idx}
- One sub-module, `rr_pick`: combinational round-robin priority picker (req vector, ptr → one-hot grant).
- The tag pipeline stays inline.

## Test plan
- NREQ=2, REQ_LATENCY=1, only req0 valid with data[k]=k, layer 1 → `rq_in_valid` at t+1 with `rq_layer_sel`=1, and `resp_valid`=2'b01 at t+2 when the model raises `rq_out_valid`.
- Both requesters continuously valid for 8 cycles → grants alternate 0,1,0,1…; each requester receives 4 `resp_valid` pulses.
- `drain` raised while 2 beats are in flight → `req_ready`=0 immediately, both responses still delivered, `idle`=1 the cycle after the last one; `drain` low → grants resume.
- `rst` asserted mid-stream with REQ_LATENCY=3 → all outputs at reset values, no `resp_valid` for discarded beats.
- `REQ_ARB_CHECK_EN` defined, model injects `rq_out_valid` with no beat in flight → `err`=1 and it stays set until `rst`.
- NREQ=3, only req2 valid, then req0 and req2 both valid → req2 granted first, then req0 (ptr wrapped to 0).

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_pkg : shared types for the requantizer arbitration slice             |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
package cnn_pkg;

  localparam int c_max_nreq = 4;
  localparam int c_idx_w    = 2;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_DRAIN   = 2'd1,
    S_DRAINED = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic               valid;
    logic [c_idx_w-1:0] idx;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, first set bit from ptr up    |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module rr_pick
  import cnn_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]    req,
  input  logic [c_idx_w-1:0] ptr,
  output logic [NREQ-1:0]    grant
);

  logic w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
          grant[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/requant_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | requant_arbiter : round-robin share of one requantize engine, tag-routed |
// | results, drain FSM. Optional REQ_ARB_CHECK_EN enables the sticky err.    |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module requant_arbiter
  import cnn_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int CH          = 16,
  parameter int ACC_W       = 32,
  parameter int REQ_LATENCY = 1,
  parameter int LSEL_W      = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ-1:0][CH-1:0][ACC_W-1:0]  req_data,
  input  logic [NREQ-1:0][LSEL_W-1:0]         req_layer,
  output logic [CH-1:0][ACC_W-1:0]            rq_in_data,
  output logic                                rq_in_valid,
  output logic [LSEL_W-1:0]                   rq_layer_sel,
  input  logic                                rq_out_valid,
  output logic [NREQ-1:0]                     resp_valid,
  input  logic                                drain,
  output logic                                idle,
  output logic                                err
);

  arb_state_t                  r_state;
  arb_state_t                  w_state_nxt;
  logic [c_idx_w-1:0]          r_ptr;
  logic [c_idx_w-1:0]          r_tag;
  logic [NREQ-1:0]             w_pick;
  logic                        w_accept;
  logic [c_idx_w-1:0]          w_gidx;
  logic [c_idx_w-1:0]          w_ptr_nxt;
  logic [CH-1:0][ACC_W-1:0]    w_sel_data;
  logic [LSEL_W-1:0]           w_sel_layer;
  tag_t [REQ_LATENCY-1:0]      r_pipe;
  tag_t                        w_head;
  logic                        w_pipe_busy;
  logic                        w_busy_nxt;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_pick)
  );

  // drain gates the grant in the same cycle it rises
  assign req_ready = (r_state == S_RUN && !drain) ? w_pick : '0;
  assign w_accept  = |(req_ready & req_valid);

  always_comb begin
    w_gidx      = '0;
    w_ptr_nxt   = '0;
    w_sel_data  = '0;
    w_sel_layer = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        w_gidx      = c_idx_w'(i);
        w_ptr_nxt   = (i == NREQ - 1) ? '0 : c_idx_w'(i + 1);
        w_sel_data  = req_data[i];
        w_sel_layer = req_layer[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= '0;
      r_tag        <= '0;
      rq_in_valid  <= 1'b0;
      rq_in_data   <= '0;
      rq_layer_sel <= '0;
    end else begin
      rq_in_valid <= w_accept;
      if (w_accept) begin
        r_ptr        <= w_ptr_nxt;
        r_tag        <= w_gidx;
        rq_in_data   <= w_sel_data;
        rq_layer_sel <= w_sel_layer;
      end
    end
  end

  // tag pipe mirrors the requantizer latency; the head lines up with out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= '{valid: rq_in_valid, idx: r_tag};
      for (int s = 1; s < REQ_LATENCY; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
    end
  end

  assign w_head = r_pipe[REQ_LATENCY-1];

  always_comb begin
    w_pipe_busy = 1'b0;
    w_busy_nxt  = rq_in_valid;
    for (int s = 0; s < REQ_LATENCY; s++) begin
      w_pipe_busy = w_pipe_busy | r_pipe[s].valid;
    end
    for (int s = 0; s < REQ_LATENCY - 1; s++) begin
      w_busy_nxt = w_busy_nxt | r_pipe[s].valid;
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rq_out_valid && w_head.valid && (w_head.idx == c_idx_w'(i))) begin
        resp_valid[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // leave S_DRAIN as soon as nothing will remain in flight next cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:     if (drain) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!drain)           w_state_nxt = S_RUN;
        else if (!w_busy_nxt) w_state_nxt = S_DRAINED;
      end
      S_DRAINED: if (!drain) w_state_nxt = S_RUN;
      default:   w_state_nxt = S_RUN;
    endcase
  end

  assign idle = !rq_in_valid && !w_pipe_busy && (r_state != S_DRAIN);

`ifdef REQ_ARB_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (rq_out_valid != w_head.valid) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_requant_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_requant_arbiter : directed bench with a queue-based reference model   |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module tb_requant_arbiter;

  localparam int CH  = 4;
  localparam int AW  = 16;
  localparam int LSW = 2;
  localparam int LA  = 1;
  localparam int LB  = 3;
`ifdef REQ_ARB_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance A: NREQ=2, latency 1
  logic                         rst_a;
  logic [1:0]                   req_valid_a, req_ready_a, resp_valid_a;
  logic [1:0][CH-1:0][AW-1:0]   req_data_a;
  logic [1:0][LSW-1:0]          req_layer_a;
  logic [CH-1:0][AW-1:0]        rq_in_data_a;
  logic                         rq_in_valid_a, rq_out_valid_a;
  logic [LSW-1:0]               rq_layer_sel_a;
  logic                         drain_a, idle_a, err_a;

  // instance B: NREQ=3, latency 3
  logic                         rst_b;
  logic [2:0]                   req_valid_b, req_ready_b, resp_valid_b;
  logic [2:0][CH-1:0][AW-1:0]   req_data_b;
  logic [2:0][LSW-1:0]          req_layer_b;
  logic [CH-1:0][AW-1:0]        rq_in_data_b;
  logic                         rq_in_valid_b, rq_out_valid_b;
  logic [LSW-1:0]               rq_layer_sel_b;
  logic                         drain_b, idle_b, err_b;

  requant_arbiter #(.NREQ(2), .CH(CH), .ACC_W(AW), .REQ_LATENCY(LA), .LSEL_W(LSW)) u_dut_a (
    .clk(clk), .rst(rst_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_data(req_data_a), .req_layer(req_layer_a), .rq_in_data(rq_in_data_a),
    .rq_in_valid(rq_in_valid_a), .rq_layer_sel(rq_layer_sel_a), .rq_out_valid(rq_out_valid_a),
    .resp_valid(resp_valid_a), .drain(drain_a), .idle(idle_a), .err(err_a)
  );

  requant_arbiter #(.NREQ(3), .CH(CH), .ACC_W(AW), .REQ_LATENCY(LB), .LSEL_W(LSW)) u_dut_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_data(req_data_b), .req_layer(req_layer_b), .rq_in_data(rq_in_data_b),
    .rq_in_valid(rq_in_valid_b), .rq_layer_sel(rq_layer_sel_b), .rq_out_valid(rq_out_valid_b),
    .resp_valid(resp_valid_b), .drain(drain_b), .idle(idle_b), .err(err_b)
  );

  // requantize engine stand-in: out_valid follows in_valid by the latency
  logic [7:0] dl_a = '0;
  logic [7:0] dl_b = '0;
  logic       out_a = 1'b0;
  logic       out_b = 1'b0;
  logic       inj_a = 1'b0;

  always @(negedge clk) begin
    dl_a <= {dl_a[6:0], rq_in_valid_a};
    dl_b <= {dl_b[6:0], rq_in_valid_b};
  end

  always @(posedge clk) begin
    out_a <= dl_a[LA-1];
    out_b <= dl_b[LB-1];
  end

  assign rq_out_valid_a = out_a | inj_a;
  assign rq_out_valid_b = out_b;

  task automatic hchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model for instance A: beats queued with their response due cycle
  typedef struct {
    int idx;
    int due;
  } beat_t;

  beat_t                  q[$];
  int                     cyc = 0;
  int                     m_ptr = 0;
  int                     m_mode = 0;
  logic                   m_iv = 1'b0;
  logic [CH-1:0][AW-1:0]  m_data = '0;
  logic [LSW-1:0]         m_layer = '0;
  logic                   m_err = 1'b0;
  int                     cnt0 = 0;
  int                     cnt1 = 0;
  logic [1:0]             e_ready, e_resp;
  int                     g, hidx;
  logic                   hit, busy;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_a) begin
        q.delete();
        m_ptr = 0; m_mode = 0; m_iv = 1'b0; m_data = '0; m_layer = '0; m_err = 1'b0;
      end
      g = -1;
      if (m_mode == 0 && !drain_a) begin
        for (int k = 0; k < 2; k++) begin
          if (g < 0 && req_valid_a[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
        end
      end
      e_ready = 2'b00;
      if (g >= 0) e_ready[g] = 1'b1;
      hit = 1'b0; hidx = 0; busy = 1'b0;
      foreach (q[j]) begin
        if (q[j].due == cyc) begin hit = 1'b1; hidx = q[j].idx; end
        if (q[j].due >= cyc) busy = 1'b1;
      end
      e_resp = 2'b00;
      if (hit && rq_out_valid_a) e_resp[hidx] = 1'b1;
      hchk("m_ready", req_ready_a, e_ready);
      hchk("m_in_valid", rq_in_valid_a, m_iv);
      hchk("m_in_data", rq_in_data_a, m_data);
      hchk("m_layer", rq_layer_sel_a, m_layer);
      hchk("m_resp", resp_valid_a, e_resp);
      hchk("m_idle", idle_a, (!busy && m_mode != 1));
      hchk("m_err", err_a, m_err);
      if (!rst_a) begin
        if (resp_valid_a[0]) cnt0++;
        if (resp_valid_a[1]) cnt1++;
        if (CHK && (hit != rq_out_valid_a)) m_err = 1'b1;
        while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
        if (g >= 0) begin
          q.push_back('{idx: g, due: cyc + 1 + LA});
          m_iv = 1'b1; m_data = req_data_a[g]; m_layer = req_layer_a[g];
          m_ptr = (g + 1) % 2;
        end else begin
          m_iv = 1'b0;
        end
        case (m_mode)
          0: if (drain_a) m_mode = 1;
          1: if (!drain_a) m_mode = 0; else if (q.size() == 0) m_mode = 2;
          default: if (!drain_a) m_mode = 0;
        endcase
      end
      cyc++;
    end
  end

  int   s0, s1;
  logic [2:0] any_b;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; drain_a = 1'b0; drain_b = 1'b0;
    req_valid_a = '0; req_data_a = '0; req_layer_a = '0;
    req_valid_b = '0; req_data_b = '0; req_layer_b = '0;
    repeat (2) @(negedge clk);
    hchk("rst_in_valid", rq_in_valid_a, 1'b0);
    hchk("rst_in_data", rq_in_data_a, '0);
    hchk("rst_layer", rq_layer_sel_a, '0);
    hchk("rst_resp", resp_valid_a, '0);
    hchk("rst_idle", idle_a, 1'b1);
    hchk("rst_err", err_a, 1'b0);
    step(); rst_a = 1'b0; rst_b = 1'b0;
    step();

    // single beat from requester 0
    req_valid_a = 2'b01;
    for (int k = 0; k < CH; k++) begin
      req_data_a[0][k] = AW'(k);
      req_data_a[1][k] = AW'(16'hB000 + k);
    end
    req_layer_a[0] = 2'd1; req_layer_a[1] = 2'd2;
    @(negedge clk); hchk("one_ready", req_ready_a, 2'b01);
    step(); req_valid_a = 2'b00;
    @(negedge clk);
    hchk("one_in_valid", rq_in_valid_a, 1'b1);
    hchk("one_layer", rq_layer_sel_a, 2'd1);
    hchk("one_data", rq_in_data_a, 64'h0003_0002_0001_0000);
    step();
    @(negedge clk); hchk("one_resp", resp_valid_a, 2'b01);

    // both requesters valid for 8 cycles
    step(); s0 = cnt0; s1 = cnt1; req_valid_a = 2'b11;
    @(negedge clk); hchk("rr_first", req_ready_a, 2'b10);
    repeat (7) step();
    step(); req_valid_a = 2'b00;
    repeat (3) step();
    hchk("rr_cnt0", cnt0 - s0, 4);
    hchk("rr_cnt1", cnt1 - s1, 4);

    // drain with two beats in flight
    s0 = cnt0 + cnt1; req_valid_a = 2'b11;
    step();
    step(); drain_a = 1'b1;
    @(negedge clk); hchk("dr_ready", req_ready_a, 2'b00); hchk("dr_idle0", idle_a, 1'b0);
    step(); @(negedge clk); hchk("dr_idle1", idle_a, 1'b0);
    step(); @(negedge clk); hchk("dr_idle2", idle_a, 1'b1);
    step(); hchk("dr_resp_cnt", cnt0 + cnt1 - s0, 2);
    drain_a = 1'b0;
    @(negedge clk); hchk("dr_still_off", req_ready_a, 2'b00);
    step(); @(negedge clk); hchk("dr_resume", |req_ready_a, 1'b1);
    step(); req_valid_a = 2'b00;
    repeat (3) step();

    // stray out_valid with nothing in flight
    inj_a = 1'b1;
    @(negedge clk); hchk("inj_resp", resp_valid_a, 2'b00);
    step(); inj_a = 1'b0;
    @(negedge clk); hchk("inj_err", err_a, CHK);
    repeat (2) step();
    @(negedge clk); hchk("inj_err_hold", err_a, CHK);
    step(); rst_a = 1'b1;
    @(negedge clk); hchk("inj_err_rst", err_a, 1'b0);
    step(); rst_a = 1'b0;

    // NREQ=3 pointer wrap
    for (int k = 0; k < CH; k++) begin
      req_data_b[0][k] = AW'(16'hA000 + k);
      req_data_b[2][k] = AW'(16'hC000 + k);
    end
    req_layer_b[0] = 2'd2; req_layer_b[2] = 2'd3;
    step(); req_valid_b = 3'b100;
    @(negedge clk); hchk("b_first", req_ready_b, 3'b100);
    step(); req_valid_b = 3'b101;
    @(negedge clk); hchk("b_wrap", req_ready_b, 3'b001);
    step();
    @(negedge clk); hchk("b_next", req_ready_b, 3'b100); hchk("b_layer", rq_layer_sel_b, 2'd2);
    step(); req_valid_b = 3'b000;
    step();
    @(negedge clk); hchk("b_resp", resp_valid_b, 3'b100);
    repeat (4) step();

    // reset in the middle of a stream at latency 3
    req_valid_b = 3'b111;
    step();
    step();
    @(negedge clk); hchk("b_stream", rq_in_valid_b, 1'b1);
    step(); rst_b = 1'b1; req_valid_b = 3'b000;
    @(negedge clk);
    hchk("b_rst_in_valid", rq_in_valid_b, 1'b0);
    hchk("b_rst_data", rq_in_data_b, '0);
    hchk("b_rst_layer", rq_layer_sel_b, '0);
    hchk("b_rst_idle", idle_b, 1'b1);
    any_b = resp_valid_b;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 1) rst_b = 1'b0;
      @(negedge clk);
      any_b = any_b | resp_valid_b;
    end
    hchk("b_no_resp", any_b, 3'b000);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
